// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared next-PC select encoding and pointer-width helper for the PC unit.
package pc_unit_pkg;
  typedef enum logic [2:0] {HOLD, INC, BRANCH, JUMP, CALL, RET} ctrl_e;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_cnt;
  logic             r_empty, r_full;
  logic             w_push, w_pop;
  logic [CW-1:0]    w_cnt_nxt;
  assign w_pop     = pop && !r_empty;
  assign w_push    = push && !pop;
  assign w_cnt_nxt = w_pop ? r_cnt - CW'(1) : (w_push && !r_full) ? r_cnt + CW'(1) : r_cnt;
  assign dout      = r_mem[r_top];
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = w_push && r_full;
  assign underflow = pop && r_empty;
  // Storage carries no reset; only pointer and count are cleared.
  always_ff @(posedge clk)
    if (reset && w_push) r_mem[r_top + PW'(1)] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_top   <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_top   <= w_pop ? r_top - PW'(1) : w_push ? r_top + PW'(1) : r_top;
      r_cnt   <= w_cnt_nxt;
      r_empty <= w_cnt_nxt == '0;
      r_full  <= w_cnt_nxt == CW'(RAS_DEPTH);
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter with branch, stall and call/return stack.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] STEP       = 4,
  parameter int               RAS_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             inc,
  input  logic             jump,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);
  logic [WIDTH-1:0] r_pc;
  logic             r_err;
  ctrl_e            w_sel;
  logic [WIDTH-1:0] w_seq, w_ras_dout, w_pc_nxt;
  logic             w_ovf, w_udf;
  always_comb
    w_sel = stall ? HOLD : ret ? RET : call ? CALL : jump ? JUMP : branch ? BRANCH : inc ? INC : HOLD;
  assign w_seq    = r_pc + STEP;
  assign w_pc_nxt = (w_sel == RET && !ras_empty)        ? w_ras_dout :
                    (w_sel == CALL || w_sel == JUMP)    ? addr :
                    (w_sel == BRANCH)                   ? r_pc + offset :
                    (w_sel == INC)                      ? w_seq : r_pc;
  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_sel == CALL),
    .pop       (w_sel == RET),
    .din       (w_seq),
    .dout      (w_ras_dout),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (w_ovf),
    .underflow (w_udf)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_pc  <= RESET_ADDR;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_err <= r_err | w_ovf | w_udf;
    end
  assign out     = r_pc;
  assign ras_err = r_err;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors feed an expectation queue; a negedge monitor pops and compares.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, inc, jump, branch, call, ret;
  logic [31:0] addr, offset, out;
  logic        ras_empty, ras_full, ras_err;
  typedef struct {
    int          id;
    int          due;
    logic [31:0] o;
    logic        e, f, er;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int cyc = 0, total = 0, bad = 0, id = 0;
  pc_unit #(.WIDTH(32), .STEP(32'd4), .RAS_DEPTH(4), .RESET_ADDR(32'h100)) dut (
    .clk(clk), .reset(reset), .stall(stall), .inc(inc), .jump(jump), .branch(branch),
    .call(call), .ret(ret), .addr(addr), .offset(offset), .out(out),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(input string nm, input int n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, n, act, req);
    end
  endfunction
  always @(negedge clk)
    while (q.size() != 0 && q[0].due <= cyc) begin
      m_e = q.pop_front();
      check("out", m_e.id, out, m_e.o);
      check("ras_empty", m_e.id, 32'(ras_empty), 32'(m_e.e));
      check("ras_full", m_e.id, 32'(ras_full), 32'(m_e.f));
      check("ras_err", m_e.id, 32'(ras_err), 32'(m_e.er));
    end
  task automatic expect_next(input logic [31:0] o, input logic e, f, er);
    q.push_back('{id, cyc + 1, o, e, f, er});
    id++;
  endtask
  task automatic op(input logic st, in, jp, br, ca, rt, input logic [31:0] ad, of,
                    input logic [31:0] o, input logic e, f, er);
    {stall, inc, jump, branch, call, ret} = {st, in, jp, br, ca, rt};
    addr = ad;
    offset = of;
    expect_next(o, e, f, er);
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    {stall, inc, jump, branch, call, ret} = '0;
    expect_next(32'h100, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask
  initial begin
    reset = 1'b0;
    {stall, inc, jump, branch, call, ret} = '0;
    addr = '0;
    offset = '0;
    #1;
    do_reset();
    //   st in jp br ca rt  addr          offset        out           e  f  err
    op(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h104,      1, 0, 0);
    op(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h108,      1, 0, 0);
    op(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h10C,      1, 0, 0);
    op(0, 0, 1, 0, 0, 0, 32'h200,      32'h0,        32'h200,      1, 0, 0);
    op(0, 0, 0, 1, 0, 0, 32'h0,        32'hFFFFFFF0, 32'h1F0,      1, 0, 0);
    op(0, 0, 1, 0, 0, 0, 32'h4000,     32'h0,        32'h4000,     1, 0, 0);
    op(1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h4000,     1, 0, 0);
    op(0, 0, 1, 0, 0, 0, 32'h10,       32'h0,        32'h10,       1, 0, 0);
    op(0, 0, 0, 0, 1, 0, 32'h80,       32'h0,        32'h80,       0, 0, 0);
    op(0, 0, 0, 0, 1, 0, 32'hC0,       32'h0,        32'hC0,       0, 0, 0);
    op(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'hC0,       0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h84,       0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h14,       1, 0, 0);
    op(0, 0, 0, 0, 1, 0, 32'h1000,     32'h0,        32'h1000,     0, 0, 0);
    op(0, 0, 0, 0, 1, 0, 32'h2000,     32'h0,        32'h2000,     0, 0, 0);
    op(0, 0, 0, 0, 1, 0, 32'h3000,     32'h0,        32'h3000,     0, 0, 0);
    op(0, 0, 0, 0, 1, 0, 32'h4000,     32'h0,        32'h4000,     0, 1, 0);
    op(0, 0, 0, 0, 1, 0, 32'h5000,     32'h0,        32'h5000,     0, 1, 1);
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h4004,     0, 0, 1);
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h3004,     0, 0, 1);
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h2004,     0, 0, 1);
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h1004,     1, 0, 1);
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h1004,     1, 0, 1);
    do_reset();
    op(0, 0, 1, 0, 0, 0, 32'h50,       32'h0,        32'h50,       1, 0, 0);
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h50,       1, 0, 1);
    op(0, 0, 0, 0, 1, 1, 32'h999,      32'h0,        32'h50,       1, 0, 1);
    op(0, 0, 0, 0, 1, 0, 32'h70,       32'h0,        32'h70,       0, 0, 1);
    op(0, 0, 0, 1, 0, 1, 32'h0,        32'h8,        32'h54,       1, 0, 1);
    op(0, 0, 1, 0, 0, 0, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 1, 0, 1);
    op(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1);
    op(0, 0, 0, 0, 1, 0, 32'h600,      32'h0,        32'h600,      0, 0, 1);
    call = 1'b1;
    addr = 32'h700;
    #2;
    reset = 1'b0;
    #1;
    check("async_out", id, out, 32'h100);
    check("async_empty", id, 32'(ras_empty), 32'd1);
    check("async_err", id, 32'(ras_err), 32'd0);
    expect_next(32'h100, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    op(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h100,      1, 0, 1);
    op(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h104,      1, 0, 1);
    {stall, inc, jump, branch, call, ret} = '0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter: successor to the fixed 32-bit increment/jump/reset PC.
- Adds configurable width and step, PC-relative branch, pipeline stall, and an internal return-address stack (RAS) for call/return.
- Sits at the front of the fetch path and drives the instruction-memory address every cycle.

Parameters:
- WIDTH, 32, PC and address width in bits.
- STEP, 4, increment amount per sequential instruction (unsigned, less than 2^WIDTH).
- RAS_DEPTH, 4, return-address stack entries (power of two, at least 2).
- RESET_ADDR, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- stall  input  1  freeze PC and RAS this cycle.
- inc  input  1  sequential advance: out + STEP.
- jump  input  1  absolute jump to addr.
- branch  input  1  relative branch: out + offset.
- call  input  1  push out + STEP onto the RAS, then jump to addr.
- ret  input  1  pop the RAS and load the popped value.
- addr  input  WIDTH  absolute target for jump and call.
- offset  input  WIDTH  two's-complement signed branch offset.
- out  output  WIDTH  current PC (registered).
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_err  output  1  sticky flag: RAS underflow or overflow has occurred.

Behaviour:
- Reset (reset=0, asynchronous):
  - out = RESET_ADDR, RAS count = 0, ras_empty = 1, ras_full = 0, ras_err = 0.
  - Takes effect immediately, independent of clk. Overrides everything, including mid-operation.
- Release: the first rising edge with reset=1 evaluates the controls normally.
- Next-PC priority, evaluated each rising edge (highest first):
  - stall: out, RAS and flags unchanged; all other controls ignored.
  - ret: if count > 0, out = top entry and count decrements. If count = 0, out holds and ras_err is set.
  - call: push out+STEP, out = addr. At count = RAS_DEPTH the oldest entry is overwritten (circular), count stays RAS_DEPTH, and ras_err is set.
  - jump: out = addr.
  - branch: out = out + offset.
  - inc: out = out + STEP.
  - none asserted: out holds.
- Arithmetic:
  - All sums are modulo 2^WIDTH; wrap-around is silent (0xFFFFFFFC + 4 = 0x00000000).
  - offset is added as WIDTH bits, so negative values wrap naturally.
- Lower-priority controls asserted together with a higher one have no effect. A simultaneous call and ret behaves as ret only; there is no push.
- Latency:
  - out reflects the selected next-PC one cycle after the edge that samples the controls.
  - ras_empty and ras_full are registered and update on the same edge as count.
- ras_err is sticky until reset and does not affect normal operation.
- RAS storage:
  - Circular buffer with a top pointer of log2(RAS_DEPTH) bits and a count from 0 to RAS_DEPTH.
  - Push writes at top+1 and advances top. Pop reads at top and retreats top.
  - Entries are not cleared on reset; only count and pointer are.

Decomposition:
- Shared package:
  - control-priority encoding as a localparam enum: HOLD, INC, BRANCH, JUMP, CALL, RET.
  - a clog2 helper for pointer width.
- Sub-module pc_ras:
  - parametrised on WIDTH and RAS_DEPTH;
  - ports: clk, reset, push, pop, din, dout, empty, full, overflow, underflow.
- pc_unit contains the priority decode, the next-PC adders and mux, the PC register and the ras_err latch.

Test Plan:
- Reset then release with WIDTH=32, STEP=4, RESET_ADDR=0x100; inc for 3 cycles -> out = 0x100, 0x104, 0x108, 0x10C; ras_empty=1.
- out=0x200 with branch=1, offset=0xFFFFFFF0 -> out=0x1F0. Then jump=1, addr=0x4000 -> out=0x4000. Then stall=1 with inc=1 -> out stays 0x4000.
- Calls from out=0x10 (addr=0x80), then out=0x80 (addr=0xC0); then ret twice -> out = 0x80, 0xC0, 0x84, 0x14; ras_empty=1 after; ras_err=0.
- Five calls with RAS_DEPTH=4 -> ras_full=1, ras_err=1. Four rets -> returns the last four pushed addresses, newest first. A fifth ret -> out holds; ras_err stays 1.
- ret on an empty RAS at out=0x50 -> out=0x50, ras_err=1. Same cycle with call+ret asserted -> treated as ret, RAS unchanged.
- out=0xFFFFFFFC with inc -> out=0x00000000. Assert reset asynchronously mid-cycle during a call -> out=RESET_ADDR before the next edge; count=0; ras_err=0.
